// File: rtl/spec_branch_predictor_if.sv
// Fetch-query and backend-resolution bundle for spec_branch_predictor.
// master drives queries/updates (fetch unit + backend); slave is the predictor.
interface spec_branch_predictor_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned GHR_BITS  = 8,
    parameter int unsigned RAS_DEPTH = 8
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    logic                flush;
    logic                ready;

    logic                fetch_valid;
    logic [ADDR_W-1:0]   fetch_pc;
    logic                pred_taken;
    logic [ADDR_W-1:0]   pred_target;
    logic [GHR_BITS-1:0] pred_hist;
    logic [PTR_W-1:0]    pred_ras_ptr;

    logic                upd0_valid;
    logic [ADDR_W-1:0]   upd0_pc;
    logic                upd0_taken;
    logic [ADDR_W-1:0]   upd0_target;
    logic [1:0]          upd0_type;
    logic [GHR_BITS-1:0] upd0_hist;
    logic [PTR_W-1:0]    upd0_ras_ptr;
    logic                upd0_mispredict;

    logic                upd1_valid;
    logic [ADDR_W-1:0]   upd1_pc;
    logic                upd1_taken;
    logic [ADDR_W-1:0]   upd1_target;
    logic [1:0]          upd1_type;
    logic [GHR_BITS-1:0] upd1_hist;
    logic [PTR_W-1:0]    upd1_ras_ptr;
    logic                upd1_mispredict;

    modport master (
        output flush, fetch_valid, fetch_pc,
        output upd0_valid, upd0_pc, upd0_taken, upd0_target, upd0_type,
               upd0_hist, upd0_ras_ptr, upd0_mispredict,
        output upd1_valid, upd1_pc, upd1_taken, upd1_target, upd1_type,
               upd1_hist, upd1_ras_ptr, upd1_mispredict,
        input  ready, pred_taken, pred_target, pred_hist, pred_ras_ptr
    );

    modport slave (
        input  flush, fetch_valid, fetch_pc,
        input  upd0_valid, upd0_pc, upd0_taken, upd0_target, upd0_type,
               upd0_hist, upd0_ras_ptr, upd0_mispredict,
        input  upd1_valid, upd1_pc, upd1_taken, upd1_target, upd1_type,
               upd1_hist, upd1_ras_ptr, upd1_mispredict,
        output ready, pred_taken, pred_target, pred_hist, pred_ras_ptr
    );
endinterface

// File: rtl/spec_branch_predictor.sv
// Gshare predictor with typed BTB, speculative GHR and circular RAS, checkpoint
// recovery from two in-order resolution ports, and a walking table-init FSM.
module spec_branch_predictor #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned GHR_BITS     = 8,
    parameter int unsigned IDX_BITS     = 8,
    parameter int unsigned CTR_BITS     = 2,
    parameter int unsigned RAS_DEPTH    = 8,
    parameter int unsigned FETCH_STRIDE = 8
) (
    input logic                    clk,
    input logic                    rst,
    spec_branch_predictor_if.slave bp
);
    localparam int unsigned PTR_W   = $clog2(RAS_DEPTH);
    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned TAG_W   = ADDR_W - IDX_BITS - 2;
    localparam int unsigned HX_W    = (GHR_BITS > IDX_BITS) ? GHR_BITS : IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [ADDR_W-1:0]   STRIDE      = ADDR_W'(FETCH_STRIDE);
    localparam logic [ADDR_W-1:0]   RET_OFS     = ADDR_W'(4);

    typedef enum logic {S_INIT, S_RUN} state_e;
    typedef enum logic [1:0] {BR_COND = 2'b00, BR_JUMP = 2'b01, BR_CALL = 2'b10, BR_RET = 2'b11} br_e;

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] init_idx_q, init_idx_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;

    logic [CTR_BITS-1:0] pht_q       [ENTRIES];
    logic [CTR_BITS-1:0] pht_d       [ENTRIES];
    logic                btb_valid_q [ENTRIES];
    logic                btb_valid_d [ENTRIES];
    logic [TAG_W-1:0]    btb_tag_q   [ENTRIES];
    logic [TAG_W-1:0]    btb_tag_d   [ENTRIES];
    logic [ADDR_W-1:0]   btb_tgt_q   [ENTRIES];
    logic [ADDR_W-1:0]   btb_tgt_d   [ENTRIES];
    logic [1:0]          btb_type_q  [ENTRIES];
    logic [1:0]          btb_type_d  [ENTRIES];
    logic [ADDR_W-1:0]   ras_q       [RAS_DEPTH];
    logic [ADDR_W-1:0]   ras_d       [RAS_DEPTH];

    // Resolution ports gathered into arrays so both are handled by one loop.
    logic                u_valid [2];
    logic [ADDR_W-1:0]   u_pc    [2];
    logic                u_taken [2];
    logic [ADDR_W-1:0]   u_tgt   [2];
    logic [1:0]          u_type  [2];
    logic [GHR_BITS-1:0] u_hist  [2];
    logic [PTR_W-1:0]    u_ptr   [2];
    logic                u_mp    [2];

    assign u_valid[0] = bp.upd0_valid;   assign u_valid[1] = bp.upd1_valid;
    assign u_pc[0]    = bp.upd0_pc;      assign u_pc[1]    = bp.upd1_pc;
    assign u_taken[0] = bp.upd0_taken;   assign u_taken[1] = bp.upd1_taken;
    assign u_tgt[0]   = bp.upd0_target;  assign u_tgt[1]   = bp.upd1_target;
    assign u_type[0]  = bp.upd0_type;    assign u_type[1]  = bp.upd1_type;
    assign u_hist[0]  = bp.upd0_hist;    assign u_hist[1]  = bp.upd1_hist;
    assign u_ptr[0]   = bp.upd0_ras_ptr; assign u_ptr[1]   = bp.upd1_ras_ptr;
    assign u_mp[0]    = bp.upd0_mispredict; assign u_mp[1] = bp.upd1_mispredict;

    logic                ready;
    logic [IDX_BITS-1:0] f_idx;
    logic [TAG_W-1:0]    f_tag;
    logic [HX_W-1:0]     ghr_x;
    logic [IDX_BITS-1:0] f_pht_idx;
    logic [1:0]          f_type;
    logic                hit;
    logic                pred_taken;
    logic [ADDR_W-1:0]   fall_through;

    assign ready        = (state_q == S_RUN);
    assign f_idx        = bp.fetch_pc[IDX_BITS+1:2];
    assign f_tag        = bp.fetch_pc[ADDR_W-1:IDX_BITS+2];
    assign ghr_x        = HX_W'(ghr_q);
    assign f_pht_idx    = ghr_x[IDX_BITS-1:0] ^ f_idx;
    assign f_type       = btb_type_q[f_idx];
    assign hit          = ready && bp.fetch_valid && btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    assign pred_taken   = hit && ((f_type != BR_COND) || pht_q[f_pht_idx][CTR_BITS-1]);
    assign fall_through = bp.fetch_pc + STRIDE;

    assign bp.ready        = ready;
    assign bp.pred_taken   = pred_taken;
    assign bp.pred_target  = !pred_taken          ? fall_through :
                             (f_type == BR_RET)   ? ras_q[ptr_q - PTR_W'(1)] : btb_tgt_q[f_idx];
    assign bp.pred_hist    = ghr_q;
    assign bp.pred_ras_ptr = ptr_q;

    logic                recover;
    logic [HX_W-1:0]     u_hx;
    logic [IDX_BITS-1:0] u_pidx;
    logic [IDX_BITS-1:0] u_bidx;
    logic [CTR_BITS-1:0] ctr;

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        ghr_d       = ghr_q;
        ptr_d       = ptr_q;
        pht_d       = pht_q;
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        btb_type_d  = btb_type_q;
        ras_d       = ras_q;
        recover     = 1'b0;
        u_hx        = '0;
        u_pidx      = '0;
        u_bidx      = '0;
        ctr         = '0;

        if (state_q == S_INIT) begin
            pht_d[init_idx_q]       = CTR_WEAK_NT;
            btb_valid_d[init_idx_q] = 1'b0;
            init_idx_d              = init_idx_q + IDX_BITS'(1);
            if (init_idx_q == '1) state_d = S_RUN;
        end else begin
            // Port 1 reads port 0's writes through the _d copies; a port-0
            // mispredict marks port 1 as wrong-path and skips it.
            for (int unsigned p = 0; p < 2; p++) begin
                if (u_valid[p] && !(p == 1 && u_valid[0] && u_mp[0])) begin
                    u_hx   = HX_W'(u_hist[p]);
                    u_pidx = u_hx[IDX_BITS-1:0] ^ u_pc[p][IDX_BITS+1:2];
                    u_bidx = u_pc[p][IDX_BITS+1:2];
                    if (u_type[p] == BR_COND) begin
                        ctr = pht_d[u_pidx];
                        if (u_taken[p] && ctr != '1)       ctr = ctr + CTR_BITS'(1);
                        else if (!u_taken[p] && ctr != '0) ctr = ctr - CTR_BITS'(1);
                        pht_d[u_pidx] = ctr;
                    end
                    if (u_taken[p]) begin
                        btb_valid_d[u_bidx] = 1'b1;
                        btb_tag_d[u_bidx]   = u_pc[p][ADDR_W-1:IDX_BITS+2];
                        btb_tgt_d[u_bidx]   = u_tgt[p];
                        btb_type_d[u_bidx]  = u_type[p];
                    end
                    if (u_mp[p]) begin
                        recover = 1'b1;
                        ghr_d   = (u_type[p] == BR_COND) ? {u_hist[p][GHR_BITS-2:0], u_taken[p]} : u_hist[p];
                        ptr_d   = u_ptr[p];
                        if (u_type[p] == BR_CALL) begin
                            ras_d[u_ptr[p]] = u_pc[p] + RET_OFS;
                            ptr_d           = u_ptr[p] + PTR_W'(1);
                        end else if (u_type[p] == BR_RET) begin
                            ptr_d = u_ptr[p] - PTR_W'(1);
                        end
                    end
                end
            end

            if (hit && !bp.flush && !recover) begin
                case (f_type)
                    BR_COND: ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken};
                    BR_CALL: begin
                        ras_d[ptr_q] = bp.fetch_pc + RET_OFS;
                        ptr_d        = ptr_q + PTR_W'(1);
                    end
                    BR_RET:  ptr_d = ptr_q - PTR_W'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            ghr_q      <= '0;
            ptr_q      <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            ghr_q       <= ghr_d;
            ptr_q       <= ptr_d;
            pht_q       <= pht_d;
            btb_valid_q <= btb_valid_d;
            btb_tag_q   <= btb_tag_d;
            btb_tgt_q   <= btb_tgt_d;
            btb_type_q  <= btb_type_d;
            ras_q       <= ras_d;
        end
    end
endmodule

// File: tb/tb_spec_branch_predictor.sv
// Self-checking bench for spec_branch_predictor: init timing, vector table for
// PHT/BTB/RAS behaviour, then hand sequences for RAS wrap, recovery, dual-port.
module tb_spec_branch_predictor;
    localparam int unsigned AW = 32;
    localparam int unsigned GB = 8;
    localparam int unsigned RD = 8;
    localparam logic [1:0] T_COND = 2'd0, T_JMP = 2'd1, T_CALL = 2'd2, T_RET = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spec_branch_predictor_if #(.ADDR_W(AW), .GHR_BITS(GB), .RAS_DEPTH(RD)) bif ();

    spec_branch_predictor #(
        .ADDR_W(AW), .GHR_BITS(GB), .IDX_BITS(8), .CTR_BITS(2),
        .RAS_DEPTH(RD), .FETCH_STRIDE(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bif)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic [1:0]  ty;
        logic [7:0]  hist;
        logic [2:0]  ptr;
        logic        mp;
    } upd_t;

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        fl;
        upd_t        u0;
        upd_t        u1;
        logic        etk;
        logic [31:0] etgt;
        logic [7:0]  ehist;
        logic [2:0]  eptr;
    } vec_t;

    typedef struct {
        string       name;
        logic        tk;
        logic [31:0] tgt;
        logic [7:0]  hist;
        logic [2:0]  ptr;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    upd_t NO;

    function automatic upd_t mku(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                 input logic [1:0] ty, input logic [7:0] hist,
                                 input logic [2:0] ptr, input logic mp);
        upd_t u;
        u.v = 1'b1; u.pc = pc; u.tk = tk; u.tgt = tgt; u.ty = ty; u.hist = hist; u.ptr = ptr; u.mp = mp;
        return u;
    endfunction

    function automatic vec_t mkv(input logic fv, input logic [31:0] fpc, input logic fl,
                                 input upd_t u0, input upd_t u1, input logic etk,
                                 input logic [31:0] etgt, input logic [7:0] ehist, input logic [2:0] eptr);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.fl = fl; v.u0 = u0; v.u1 = u1;
        v.etk = etk; v.etgt = etgt; v.ehist = ehist; v.eptr = eptr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_upd0(input upd_t u);
        bif.upd0_valid = u.v; bif.upd0_pc = u.pc; bif.upd0_taken = u.tk; bif.upd0_target = u.tgt;
        bif.upd0_type = u.ty; bif.upd0_hist = u.hist; bif.upd0_ras_ptr = u.ptr; bif.upd0_mispredict = u.mp;
    endtask

    task automatic set_upd1(input upd_t u);
        bif.upd1_valid = u.v; bif.upd1_pc = u.pc; bif.upd1_taken = u.tk; bif.upd1_target = u.tgt;
        bif.upd1_type = u.ty; bif.upd1_hist = u.hist; bif.upd1_ras_ptr = u.ptr; bif.upd1_mispredict = u.mp;
    endtask

    task automatic idle();
        bif.fetch_valid = 1'b0;
        bif.fetch_pc    = '0;
        bif.flush       = 1'b0;
        set_upd0(NO);
        set_upd1(NO);
    endtask

    task automatic drive(input string name, input logic fv, input logic [31:0] fpc, input logic fl,
                         input logic etk, input logic [31:0] etgt, input logic [7:0] ehist,
                         input logic [2:0] eptr);
        exp_t e;
        bif.fetch_valid = fv;
        bif.fetch_pc    = fpc;
        bif.flush       = fl;
        e.name = name; e.tk = etk; e.tgt = etgt; e.hist = ehist; e.ptr = eptr;
        sbq.push_back(e);
    endtask

    // Compare queued predictions mid-cycle, then advance one clock.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({e.name, ".taken"},  {31'd0, bif.pred_taken}, {31'd0, e.tk});
            chk({e.name, ".target"}, bif.pred_target, e.tgt);
            chk({e.name, ".hist"},   {24'd0, bif.pred_hist}, {24'd0, e.hist});
            chk({e.name, ".ptr"},    {29'd0, bif.pred_ras_ptr}, {29'd0, e.ptr});
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        NO = '{v: 1'b0, pc: '0, tk: 1'b0, tgt: '0, ty: '0, hist: '0, ptr: '0, mp: 1'b0};
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready", {31'd0, bif.ready}, 32'd0);
        chk("reset.hist", {24'd0, bif.pred_hist}, 32'd0);
        chk("reset.ptr", {29'd0, bif.pred_ras_ptr}, 32'd0);
        rst = 1'b0;

        // Partial init, then reset again: the count must restart from zero.
        repeat (100) @(posedge clk);
        #1;
        chk("init_partial.ready", {31'd0, bif.ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("init_restart.ready", {31'd0, bif.ready}, 32'd0);

        for (int c = 1; c <= 256; c++) begin
            if (c == 200) begin
                set_upd0(mku(32'h1000, 1'b1, 32'h3000, T_JMP, 8'h00, 3'd0, 1'b0));
                drive("init_fetch", 1'b1, 32'h1000, 1'b0, 1'b0, 32'h1008, 8'h00, 3'd0);
            end
            cycle();
            chk($sformatf("init_ready_c%0d", c), {31'd0, bif.ready}, {31'd0, (c == 256)});
        end

        // fv fpc flush u0 u1 | taken target hist ptr
        vecs.push_back(mkv(1, 32'h1000, 0, mku(32'h100, 1, 32'h200, T_COND, 8'h00, 0, 0), NO, 0, 32'h1008, 8'h00, 0));
        vecs.push_back(mkv(0, 32'h0,    0, mku(32'h100, 1, 32'h200, T_COND, 8'h00, 0, 0), NO, 0, 32'h8,    8'h00, 0));
        vecs.push_back(mkv(1, 32'h100,  1, mku(32'h100, 0, 32'h0,   T_COND, 8'h00, 0, 0), NO, 1, 32'h200,  8'h00, 0));
        vecs.push_back(mkv(1, 32'h100,  1, mku(32'h100, 0, 32'h0,   T_COND, 8'h00, 0, 0), NO, 1, 32'h200,  8'h00, 0));
        vecs.push_back(mkv(1, 32'h100,  0, mku(32'h100, 0, 32'h0,   T_COND, 8'h00, 0, 0), NO, 0, 32'h108,  8'h00, 0));
        vecs.push_back(mkv(0, 32'h0,    0, mku(32'h100, 0, 32'h0,   T_COND, 8'h00, 0, 0), NO, 0, 32'h8,    8'h00, 0));
        vecs.push_back(mkv(1, 32'h100,  1, NO, NO,                                            0, 32'h108,  8'h00, 0));
        vecs.push_back(mkv(0, 32'h0,    0, mku(32'h100, 1, 32'h200, T_COND, 8'h00, 0, 0), NO, 0, 32'h8,    8'h00, 0));
        vecs.push_back(mkv(0, 32'h0,    0, mku(32'h100, 1, 32'h200, T_COND, 8'h00, 0, 0),
                                           mku(32'h100, 1, 32'h200, T_COND, 8'h00, 0, 0),     0, 32'h8,    8'h00, 0));
        vecs.push_back(mkv(0, 32'h0,    0, mku(32'h100, 0, 32'h0,   T_COND, 8'h00, 0, 0), NO, 0, 32'h8,    8'h00, 0));
        vecs.push_back(mkv(1, 32'h100,  1, mku(32'h100, 1, 32'h200, T_COND, 8'h00, 0, 0), NO, 1, 32'h200,  8'h00, 0));
        vecs.push_back(mkv(0, 32'h0,    0, mku(32'h100, 1, 32'h200, T_COND, 8'h00, 0, 0), NO, 0, 32'h8,    8'h00, 0));
        vecs.push_back(mkv(0, 32'h0,    0, mku(32'h100, 0, 32'h0,   T_COND, 8'h00, 0, 0), NO, 0, 32'h8,    8'h00, 0));
        vecs.push_back(mkv(1, 32'h100,  0, NO, NO,                                            1, 32'h200,  8'h00, 0));
        vecs.push_back(mkv(1, 32'h100,  1, mku(32'h40, 1, 32'h400, T_CALL, 8'h55, 5, 0),
                                           mku(32'h80, 1, 32'h999, T_RET,  8'h66, 6, 0),      0, 32'h108,  8'h01, 0));
        vecs.push_back(mkv(1, 32'h40,   0, NO, NO,                                            1, 32'h400,  8'h01, 0));
        vecs.push_back(mkv(1, 32'h80,   0, NO, NO,                                            1, 32'h44,   8'h01, 1));
        vecs.push_back(mkv(0, 32'h0,    0, NO, NO,                                            0, 32'h8,    8'h01, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            set_upd0(vecs[i].u0);
            set_upd1(vecs[i].u1);
            drive($sformatf("vec%0d", i), vecs[i].fv, vecs[i].fpc, vecs[i].fl,
                  vecs[i].etk, vecs[i].etgt, vecs[i].ehist, vecs[i].eptr);
            cycle();
        end

        // RAS wrap: nine calls into an eight-deep stack, then eight returns.
        for (int k = 0; k < 9; k += 2) begin
            set_upd0(mku(32'h1004 + 8 * k, 1, 32'h4000 + 32'h100 * k, T_CALL, 8'h00, 0, 0));
            if (k + 1 < 9)
                set_upd1(mku(32'h1004 + 8 * (k + 1), 1, 32'h4000 + 32'h100 * (k + 1), T_CALL, 8'h00, 0, 0));
            drive($sformatf("ras_install%0d", k), 0, 32'h0, 0, 0, 32'h8, 8'h01, 3'd0);
            cycle();
        end
        for (int k = 0; k < 9; k++) begin
            drive($sformatf("ras_call%0d", k), 1, 32'h1004 + 8 * k, 0, 1,
                  32'h4000 + 32'h100 * k, 8'h01, 3'(k));
            cycle();
        end
        for (int j = 0; j < 8; j++) begin
            drive($sformatf("ras_ret%0d", j), 1, 32'h80, 0, 1,
                  32'h1008 + 8 * (8 - j), 8'h01, 3'(1 - j));
            cycle();
        end

        // Recovery: steer GHR to 0x2D, speculate a not-taken cond to 0x5A,
        // then a cond mispredict restores 0x58 and kills the same-cycle fetch.
        set_upd0(mku(32'h600, 1, 32'h700, T_JMP, 8'h2D, 3'd1, 1'b1));
        drive("rec_steer", 0, 32'h0, 0, 0, 32'h8, 8'h01, 3'd1);
        cycle();
        drive("rec_spec", 1, 32'h100, 0, 0, 32'h108, 8'h2D, 3'd1);
        cycle();
        set_upd0(mku(32'h300, 0, 32'h0, T_COND, 8'h2C, 3'd5, 1'b1));
        drive("rec_cond", 1, 32'h100, 0, 0, 32'h108, 8'h5A, 3'd1);
        cycle();
        drive("rec_after", 0, 32'h0, 0, 0, 32'h8, 8'h58, 3'd5);
        cycle();
        set_upd0(mku(32'h500, 1, 32'h800, T_CALL, 8'h11, 3'd3, 1'b1));
        drive("rec_call", 1, 32'h80, 0, 1, 32'h1028, 8'h58, 3'd5);
        cycle();
        drive("rec_ret", 1, 32'h80, 0, 1, 32'h504, 8'h11, 3'd4);
        cycle();
        set_upd0(mku(32'h100, 1, 32'h200, T_COND, 8'h00, 3'd0, 1'b0));
        set_upd1(mku(32'h640, 0, 32'h0, T_JMP, 8'h3C, 3'd6, 1'b1));
        drive("rec_p1", 0, 32'h0, 0, 0, 32'h8, 8'h11, 3'd3);
        cycle();
        drive("rec_p1_after", 0, 32'h0, 0, 0, 32'h8, 8'h3C, 3'd6);
        cycle();

        // Port-0 mispredict makes port 1 wrong-path: no BTB write, no recovery.
        set_upd0(mku(32'h600, 1, 32'h700, T_JMP, 8'h00, 3'd0, 1'b1));
        set_upd1(mku(32'h2000, 1, 32'h2222, T_JMP, 8'h77, 3'd7, 1'b1));
        drive("dual_kill", 0, 32'h0, 0, 0, 32'h8, 8'h3C, 3'd6);
        cycle();
        drive("dual_after", 1, 32'h2000, 1, 0, 32'h2008, 8'h00, 3'd0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spec_branch_predictor.md
# spec_branch_predictor

Next-generation front-end predictor for the IF stage. It is a parametrised gshare with:
- a PC-indexed, typed BTB;
- a speculative global history register (GHR) and circular return-address stack (RAS), both updated at fetch time;
- checkpoint/restore of GHR and RAS pointer on mispredict;
- a walking table-init state machine after reset.

It answers one fetch query per cycle combinationally and takes two in-order resolution ports from the backend.

## Interface
Parameters:
- ADDR_W, 32: instruction address width.
- GHR_BITS, 8: global history length (≥2).
- IDX_BITS, 8: PHT/BTB index width; entries = 2^IDX_BITS.
- CTR_BITS, 2: PHT saturating-counter width (≥1).
- RAS_DEPTH, 8: RAS entries, power of two; PTR_W = log2(RAS_DEPTH).
- FETCH_STRIDE, 8: fall-through increment for a fetch batch.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk, in, 1: clock.
  - rst, in, 1: synchronous active-high reset.
- Control:
  - flush, in, 1: drop the fetch-side speculative update this cycle.
  - ready, out, 1: table init done; predictions and updates are honoured only when 1.
- Fetch query:
  - fetch_valid, in, 1: fetch query valid.
  - fetch_pc, in, ADDR_W: fetch address.
  - pred_taken, out, 1: predicted redirect.
  - pred_target, out, ADDR_W: next fetch address.
  - pred_hist, out, GHR_BITS: GHR checkpoint, sampled before this fetch's speculative shift.
  - pred_ras_ptr, out, PTR_W: RAS pointer checkpoint, sampled before this fetch's push/pop.
- Update ports: updN_* for N=0,1, applied in order 0 then 1.
  - updN_valid, in, 1.
  - updN_pc, in, ADDR_W.
  - updN_taken, in, 1: actual outcome.
  - updN_target, in, ADDR_W: actual target.
  - updN_type, in, 2: branch type, 00 cond, 01 jump, 10 call, 11 return.
  - updN_hist, in, GHR_BITS: checkpoint carried from fetch.
  - updN_ras_ptr, in, PTR_W: checkpoint carried from fetch.
  - updN_mispredict, in, 1: direction or target was wrong.

## Operation
- States are INIT and RUN.
  - rst=1 forces INIT with init_idx=0. Each INIT cycle writes entry init_idx:
    - PHT = 2^(CTR_BITS-1)-1 (weakly not-taken);
    - btb_valid = 0.
  - After entry 2^IDX_BITS-1 is written, the state moves to RUN and ready=1.
  - rst asserted mid-INIT or mid-RUN restarts INIT at index 0.
  - In INIT: pred_taken=0, pred_target=fetch_pc+FETCH_STRIDE, and all updates are ignored.
- Indexing:
  - PHT index = GHR[IDX_BITS-1:0] XOR pc[IDX_BITS+1:2]. If GHR_BITS < IDX_BITS, the GHR is zero-extended.
  - BTB index = pc[IDX_BITS+1:2]. BTB tag = pc[ADDR_W-1:IDX_BITS+2].
  - BTB entry fields: valid, tag, target, type.
- Prediction:
  - hit = ready & fetch_valid & valid & tag match.
  - pred_taken = hit & (type≠cond | PHT counter MSB).
  - pred_target:
    - return → RAS[ptr-1] (mod depth);
    - other taken types → BTB target;
    - otherwise → fetch_pc+FETCH_STRIDE. All address arithmetic wraps mod 2^ADDR_W.
- Fetch speculation applies on hit & !flush & no recovery this cycle:
  - cond: GHR ← {GHR[GHR_BITS-2:0], pred_taken};
  - call: RAS[ptr] ← fetch_pc+4, ptr ← ptr+1;
  - return: ptr ← ptr-1;
  - jump: no speculative change.
- RAS is purely circular:
  - a push with all entries occupied overwrites the oldest entry;
  - a pop on empty still decrements, and the target is whatever the slot holds.
- Update, per valid port, in RUN:
  - cond: the PHT counter at index(updN_hist, updN_pc) saturates up on taken, down on not-taken, within 0..2^CTR_BITS-1.
  - Any taken update writes the BTB entry: valid=1, tag, target, type.
  - Not-taken cond updates do not invalidate the BTB.
  - When both ports hit the same PHT or BTB entry, port 1 operates on port 0's result.
- Recovery when updN_mispredict=1:
  - GHR ← cond ? {updN_hist[GHR_BITS-2:0], updN_taken} : updN_hist.
  - ptr ← updN_ras_ptr, then +1 for call (writing RAS[updN_ras_ptr] ← updN_pc+4) or −1 for return.
  - If port 0 mispredicts, port 1 is wrong-path and is ignored entirely that cycle.
  - Any recovery cancels that cycle's fetch speculation.
- Non-mispredicted updates never touch GHR or ptr.

## Timing
- Prediction outputs are combinational from fetch_pc and current state, with zero latency.
- State written at the clock edge is visible to the query in the next cycle.
- Reset values: ready=0, GHR=0, ptr=0, state=INIT, init_idx=0.
  - pred_taken=0 and pred_hist=0 while in INIT.
- ready rises exactly 2^IDX_BITS cycles after the first clock with rst=0.
- Recovery priority in one cycle: port-0 mispredict > port-1 mispredict > fetch speculation.

## Test plan
- Init: release rst with IDX_BITS=8 → ready=0 for 256 cycles, 1 on cycle 257. Re-assert rst at cycle 100 → ready stays 0 and the count restarts.
- Conditional training: 2 taken updates for pc 0x100, target 0x200, type cond, hist 0 → fetch 0x100 with GHR 0 gives pred_taken=1, pred_target=0x200. Two not-taken updates then give pred_taken=0, pred_target=0x108.
- Call/return: BTB has call@0x40 and ret@0x80. Fetch 0x40 pushes 0x44. Fetch 0x80 gives pred_target=0x44 and ptr back to its original value.
- RAS wrap: 9 speculative calls with RAS_DEPTH=8 → the first slot is overwritten with the 9th return address. 8 returns then yield calls 9..2, most recent first.
- Mispredict recovery: the cond prediction leaves GHR=0x5A. Then upd0 arrives with mispredict=1, hist=0x2C, taken=0 → next-cycle GHR=0x58 and the same-cycle fetch speculation is dropped.
- Dual port: port 0 mispredicts and port 1 is valid taken to a fresh pc → port 1's BTB entry is not written. With both ports non-mispredict on the same cond index (counter=1, both taken), the counter ends at 3.
